// File: rtl/mul_div_sequencer.sv
// Sequential unsigned multiplier / restoring divider, one iteration per clock.
// Multiply is shift-add LSB-first; divide is restoring MSB-first; both run WIDTH steps.
module mul_div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             op_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] val_a_i,
  input  logic [WIDTH-1:0] val_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] res_lo_o,
  output logic [WIDTH-1:0] res_hi_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_q, op_d;
  logic              dz_q, dz_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  // hi: accumulator / partial remainder; lo: multiplier->product low / dividend->quotient.
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH-1:0]  div_diff;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // Remainder after a successful trial is below the divisor, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dz_d    = dz_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          cnt_d = '0;
          op_d  = op_i;
          dz_d  = 1'b0;
          hi_d  = '0;
          if (op_i && (val_b_i == '0)) begin
            state_d = StDone;
            dz_d    = 1'b1;
            lo_d    = '1;
            hi_d    = val_a_i;
          end else begin
            state_d = StRun;
            lo_d    = op_i ? val_a_i : val_b_i;
            opnd_d  = op_i ? val_b_i : val_a_i;
          end
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          if (op_q) begin
            hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == LastStep) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      dz_q    <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o     = (state_q == StRun);
  assign done_o     = (state_q == StDone);
  assign div_zero_o = dz_q;
  assign res_lo_o   = lo_q;
  assign res_hi_o   = hi_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed self-checking bench for mul_div_sequencer with hand-computed expectations.
module tb_mul_div_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] val_a = '0;
  logic [W-1:0] val_b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] res_lo, res_hi;

  int checks = 0;
  int errors = 0;

  mul_div_sequencer #(.WIDTH(W)) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .abort_i    (abort),
    .val_a_i    (val_a),
    .val_b_i    (val_b),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .res_lo_o   (res_lo),
    .res_hi_o   (res_hi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge; scramble operands afterwards to show they are not re-sampled.
  task automatic launch(input bit sync, input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    if (sync) @(negedge clk);
    op    = o;
    val_a = a;
    val_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    val_a = ~a;
    val_b = b + 32'd1;
  endtask

  // Returns number of negedges after the start edge before done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input bit sync, input logic o,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input logic exp_dz, input int exp_lat);
    int lat, bc;
    launch(sync, o, a, b);
    wait_done(lat, bc);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_busy"}, 64'(bc), 64'(exp_lat));
    check_eq({tag, "_hi"}, 64'(res_hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(res_lo), 64'(exp_lo));
    check_eq({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
  endtask

  initial begin
    int lat, bc, done_seen;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dz", 64'(div_zero), 64'd0);
    check_eq("rst_lo", 64'(res_lo), 64'd0);
    check_eq("rst_hi", 64'(res_hi), 64'd0);

    // Release reset and start on the very first edge afterwards
    rst_n = 1'b1;
    run_check("mul7x6", 1'b0, 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 32);

    // Results hold in IDLE after the done pulse
    @(negedge clk);
    check_eq("hold_done", 64'(done), 64'd0);
    check_eq("hold_lo", 64'(res_lo), 64'h2A);
    check_eq("hold_busy", 64'(busy), 64'd0);

    run_check("mulmax", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32);
    run_check("div100_7", 1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
    run_check("div8000_1", 1'b1, 1'b1, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 1'b0, 32);
    run_check("div5_0", 1'b1, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
    // divZero is cleared by the next accepted start
    run_check("divdb", 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 32'hF, 32'h0DEA_DBEE, 1'b0, 32);

    // Start during RUN (step 5) is ignored
    launch(1'b1, 1'b0, 32'd7, 32'd6);
    repeat (6) @(negedge clk);
    op = 1'b1; val_a = 32'd1; val_b = 32'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    check_eq("ign_lat", 64'(lat), 64'd26);
    check_eq("ign_lo", 64'(res_lo), 64'h2A);
    check_eq("ign_hi", 64'(res_hi), 64'h0);
    check_eq("ign_dz", 64'(div_zero), 64'd0);

    // Abort at step 10
    launch(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 64'(busy), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check_eq("abort_nodone", 64'(done_seen), 64'd0);
    run_check("mul3x3", 1'b1, 1'b0, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, 32);

    // Reset at step 20
    launch(1'b1, 1'b0, 32'd123, 32'd456);
    repeat (21) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", 64'(busy), 64'd0);
    check_eq("mrst_done", 64'(done), 64'd0);
    check_eq("mrst_lo", 64'(res_lo), 64'd0);
    check_eq("mrst_hi", 64'(res_hi), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    check_eq("mrst_nodone", 64'(done_seen), 64'd0);

    // Back-to-back: start (with abort) in DONE wins, second done 33 cycles later
    run_check("b2b_a", 1'b1, 1'b0, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, 32);
    abort = 1'b1;
    launch(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h10);
    abort = 1'b0;
    wait_done(lat, bc);
    check_eq("b2b_gap", 64'(lat + 1), 64'd33);
    check_eq("b2b_lo", 64'(res_lo), 64'h0DEA_DBEE);
    check_eq("b2b_hi", 64'(res_hi), 64'hF);
    @(negedge clk);
    check_eq("b2b_idle", 64'(done), 64'd0);
    check_eq("b2b_hold", 64'(res_lo), 64'h0DEA_DBEE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32; operand and result width in bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-005 op  input  1  operation select: 0 = unsigned multiply, 1 = unsigned divide.
REQ-006 abort  input  1  cancel the operation in progress.
REQ-007 valA  input  WIDTH  multiplicand or dividend.
REQ-008 valB  input  WIDTH  multiplier or divisor.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  high for exactly the one cycle spent in DONE.
REQ-011 divZero  output  1  divide-by-zero flag, valid with done.
REQ-012 resLo  output  WIDTH  product low word, or quotient.
REQ-013 resHi  output  WIDTH  product high word, or remainder.

Function
REQ-014 The block SHALL implement exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE/DONE with start=1 SHALL latch valA, valB and op, clear the 5-bit step counter and the accumulator, and enter RUN on the same edge.
REQ-016 DONE with start=0 SHALL return to IDLE on the next edge; start in DONE SHALL be accepted (back-to-back operation, no IDLE cycle).
REQ-017 Start while in RUN SHALL be ignored, with no effect on operands or results.
REQ-018 RUN SHALL perform one iteration per cycle, 32 iterations (steps 0..31); after step 31 the block SHALL enter DONE.
REQ-019 Latency: start sampled at edge N -> done=1 in the cycle following edge N+32; busy=1 for cycles after edges N..N+31.
REQ-020 Multiply: radix-2 shift-add over the multiplier LSB-first, using a WIDTH+1-bit accumulator; {resHi,resLo} = valA*valB, exact 64-bit unsigned result.
REQ-021 Divide: restoring division, MSB-first, using a WIDTH+1-bit trial subtract; resLo = valA / valB, resHi = valA % valB (unsigned).
REQ-022 Divide with valB==0 SHALL skip RUN: start edge -> DONE directly, with divZero=1, resLo=all ones, resHi=valA.
REQ-023 divZero SHALL be 0 for every multiply and for every divide with a nonzero divisor; it SHALL be cleared on each accepted start.
REQ-024 abort=1 in RUN SHALL force IDLE on the next edge, with no done pulse, and SHALL leave resLo/resHi at unspecified partial values; abort in IDLE/DONE SHALL be ignored.
REQ-025 If abort and start coincide in DONE, start SHALL win.
REQ-026 resLo/resHi/divZero SHALL be stable from DONE until the next accepted start.
REQ-027 Input changes on valA/valB/op after the start edge SHALL NOT affect the result.
REQ-028 The counter SHALL NOT wrap: step 31 always exits RUN.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, with busy=0, done=0, divZero=0, resLo=0, resHi=0, and the counter at 0, regardless of state.
REQ-030 Reset asserted mid-RUN SHALL discard the operation; no done pulse SHALL follow reset release.
REQ-031 The first edge after rst_n rises SHALL be able to accept start.

Verification
REQ-032 MUL 7 x 6 -> done at edge N+32; resHi=0x00000000, resLo=0x0000002A, divZero=0.
REQ-033 MUL 0xFFFFFFFF x 0xFFFFFFFF -> resHi=0xFFFFFFFE, resLo=0x00000001.
REQ-034 DIV 100 / 7 -> resLo=14, resHi=2; DIV 0x80000000 / 1 -> resLo=0x80000000, resHi=0.
REQ-035 DIV 5 / 0 -> done on the cycle after the start edge; divZero=1, resLo=0xFFFFFFFF, resHi=5; busy never asserted.
REQ-036 Abort at step 10 -> IDLE next edge, no done pulse; a new MUL 3 x 3 then yields resLo=9; start asserted at step 5 is ignored (the original result is unchanged).
REQ-037 rst_n pulsed low at step 20 -> all outputs 0 immediately, no done pulse; back-to-back start in DONE -> second done exactly 33 cycles after the first.
